// File: rtl/piso_framer_pkg.sv
// piso_framer_pkg: frame state type and line levels shared by piso_framer
package piso_framer_pkg;
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} piso_state_t;
    localparam logic START_BIT  = 1'b1;
    localparam logic STOP_BIT   = 1'b0;
    localparam logic IDLE_LEVEL = 1'b0;
endpackage

// File: rtl/piso_framer_if.sv
// piso_framer_if: valid/ready word handshake into the framer
interface piso_framer_if #(parameter int DATA_W = 8);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    modport master (output in_valid, output in_data, input in_ready);
    modport slave  (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/piso_framer.sv
// piso_framer: word-to-bitstream framer (start, data, optional even parity under PISO_FRAMER_PARITY_EN, stop)
module piso_framer
    import piso_framer_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter bit MSB_FIRST = 1
) (
    input  logic            clk,
    input  logic            rst,
    piso_framer_if.slave    in_if,
    output logic            serial_out,
    output logic            busy,
    output logic            frame_done
);
    localparam int CW = $clog2(DATA_W);
`ifdef PISO_FRAMER_PARITY_EN
    localparam piso_state_t AFTER_DATA = PARITY;
    logic par_q, par_d;
`else
    localparam piso_state_t AFTER_DATA = STOP;
`endif
    piso_state_t       state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [DATA_W-1:0] sh_q, sh_d, sh_adv;
    logic              ser_q, ser_d, busy_q, busy_d, done_q, done_d;
    logic              hs, last, next_bit;

    assign in_if.in_ready = (state_q == IDLE) || (state_q == STOP);
    assign hs     = in_if.in_valid && in_if.in_ready;
    assign last   = cnt_q == CW'(DATA_W - 1);
    assign sh_adv = MSB_FIRST ? {sh_q[DATA_W-2:0], 1'b0} : {1'b0, sh_q[DATA_W-1:1]};

    // Outputs are registered from the next state so they line up with state_q.
    always_comb begin
        state_d  = (state_q == IDLE || state_q == STOP) ? (hs ? START : IDLE)
                 : (state_q == START) ? DATA
                 : (state_q == DATA) ? (last ? AFTER_DATA : DATA)
                 : STOP;
        cnt_d    = (state_q == DATA && !last) ? cnt_q + CW'(1) : '0;
        sh_d     = hs ? in_if.in_data : (state_q == DATA) ? sh_adv : sh_q;
        next_bit = MSB_FIRST ? sh_d[DATA_W-1] : sh_d[0];
        ser_d    = (state_d == START) ? START_BIT
                 : (state_d == DATA) ? next_bit
                 : (state_d == STOP) ? STOP_BIT
                 : IDLE_LEVEL;
`ifdef PISO_FRAMER_PARITY_EN
        par_d    = hs ? ^in_if.in_data : par_q;
        if (state_d == PARITY) ser_d = par_q;
`endif
        busy_d   = (state_d == START) || (state_d == DATA) || (state_d == PARITY);
        done_d   = state_d == STOP;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            sh_q    <= '0;
            ser_q   <= IDLE_LEVEL;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef PISO_FRAMER_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sh_q    <= sh_d;
            ser_q   <= ser_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef PISO_FRAMER_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    assign serial_out = ser_q;
    assign busy       = busy_q;
    assign frame_done = done_q;
endmodule

// File: tb/tb_piso_framer.sv
// tb_piso_framer: directed checks of framing, back-to-back, busy-ignore, reset and LSB-first order
module tb_piso_framer;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    piso_framer_if #(.DATA_W(8)) m_if();
    piso_framer_if #(.DATA_W(8)) l_if();
    logic m_ser, m_busy, m_done, l_ser, l_busy, l_done;

    piso_framer #(.DATA_W(8), .MSB_FIRST(1)) u_msb (
        .clk(clk), .rst(rst), .in_if(m_if.slave),
        .serial_out(m_ser), .busy(m_busy), .frame_done(m_done)
    );
    piso_framer #(.DATA_W(8), .MSB_FIRST(0)) u_lsb (
        .clk(clk), .rst(rst), .in_if(l_if.slave),
        .serial_out(l_ser), .busy(l_busy), .frame_done(l_done)
    );

`ifdef PISO_FRAMER_PARITY_EN
    localparam int FL = 11;
    localparam logic [31:0] E_A5   = 32'b1_10100101_0_0;
    localparam logic [31:0] E_07   = 32'b1_00000111_1_0;
    localparam logic [31:0] E_FF00 = 32'b1_11111111_0_0_1_00000000_0_0;
    localparam logic [31:0] E_81   = 32'b1_10000001_0_0;
    localparam logic [31:0] E_L01  = 32'b1_10000000_1_0;
`else
    localparam int FL = 10;
    localparam logic [31:0] E_A5   = 32'b1_10100101_0;
    localparam logic [31:0] E_07   = 32'b1_00000111_0;
    localparam logic [31:0] E_FF00 = 32'b1_11111111_0_1_00000000_0;
    localparam logic [31:0] E_81   = 32'b1_10000001_0;
    localparam logic [31:0] E_L01  = 32'b1_10000000_0;
`endif
    localparam logic [31:0] B1 = (32'd1 << FL) - 32'd2;
    localparam logic [31:0] D1 = 32'd1;
    localparam logic [31:0] B2 = (B1 << FL) | B1;
    localparam logic [31:0] D2 = (32'd1 << FL) | 32'd1;

    int checks = 0;
    int failures = 0;
    logic [31:0] vs, vb, vd;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic capture(input bit lsb, input int n, input int drop_at);
        vs = '0;
        vb = '0;
        vd = '0;
        for (int i = 0; i < n; i++) begin
            vs = {vs[30:0], lsb ? l_ser : m_ser};
            vb = {vb[30:0], lsb ? l_busy : m_busy};
            vd = {vd[30:0], lsb ? l_done : m_done};
            if (i == drop_at) begin
                m_if.in_valid = 1'b0;
                l_if.in_valid = 1'b0;
            end
            tick();
        end
    endtask

    task automatic send_m(input logic [7:0] d);
        m_if.in_valid = 1'b1;
        m_if.in_data  = d;
        tick();
        m_if.in_valid = 1'b0;
    endtask

    initial begin
        m_if.in_valid = 1'b0;
        m_if.in_data  = '0;
        l_if.in_valid = 1'b0;
        l_if.in_data  = '0;
        repeat (2) tick();
        chk("reset_msb", {28'd0, m_ser, m_busy, m_done, m_if.in_ready}, 32'b0001);
        chk("reset_lsb", {28'd0, l_ser, l_busy, l_done, l_if.in_ready}, 32'b0001);
        rst = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("idle", {28'd0, m_ser, m_busy, m_done, m_if.in_ready}, 32'b0001);
        end

        send_m(8'hA5);
        capture(1'b0, FL, -1);
        chk("a5_serial", vs, E_A5);
        chk("a5_busy", vb, B1);
        chk("a5_done", vd, D1);
        chk("a5_ready_after", {31'd0, m_if.in_ready}, 32'd1);

        send_m(8'h07);
        capture(1'b0, FL, -1);
        chk("07_serial", vs, E_07);
        chk("07_done", vd, D1);

        m_if.in_valid = 1'b1;
        m_if.in_data  = 8'hFF;
        tick();
        m_if.in_data  = 8'h00;
        capture(1'b0, 2 * FL, FL);
        chk("b2b_serial", vs, E_FF00);
        chk("b2b_busy", vb, B2);
        chk("b2b_done", vd, D2);
        chk("b2b_idle_after", {31'd0, m_ser}, 32'd0);

        m_if.in_valid = 1'b1;
        m_if.in_data  = 8'h81;
        tick();
        m_if.in_data  = 8'h3C;
        capture(1'b0, FL, FL - 2);
        chk("ignore_serial", vs, E_81);
        chk("ignore_done", vd, D1);

        m_if.in_valid = 1'b1;
        m_if.in_data  = 8'hA5;
        l_if.in_valid = 1'b1;
        l_if.in_data  = 8'hFF;
        tick();
        m_if.in_valid = 1'b0;
        l_if.in_valid = 1'b0;
        repeat (4) tick();
        chk("pre_rst_bit3_msb", {31'd0, m_ser}, 32'd0);
        chk("pre_rst_bit3_lsb", {31'd0, l_ser}, 32'd1);
        rst = 1'b0;
        tick();
        chk("midrst_msb", {28'd0, m_ser, m_busy, m_done, m_if.in_ready}, 32'b0001);
        chk("midrst_lsb", {28'd0, l_ser, l_busy, l_done, l_if.in_ready}, 32'b0001);
        l_if.in_valid = 1'b1;
        l_if.in_data  = 8'h01;
        tick();
        chk("rst_beats_hs", {28'd0, l_ser, l_busy, l_done, l_if.in_ready}, 32'b0001);
        rst = 1'b1;
        tick();
        l_if.in_valid = 1'b0;
        capture(1'b1, FL, -1);
        chk("lsb01_serial", vs, E_L01);
        chk("lsb01_busy", vb, B1);
        chk("lsb01_done", vd, D1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/piso_framer.md
# piso_framer

Parallel-in serial-out framer that sits directly upstream of the serial shift-register stages and drives their `serial_in`. It accepts one `DATA_W`-bit word per valid/ready handshake. It emits the word as a framed bitstream, one bit per clock: start bit, data bits, optional parity bit, then a stop bit. The idle line level is 0, which matches the reset level of the downstream shift stages.

## Interface
- `DATA_W`, default 8: payload width in bits; legal range is 2 or more.
- `MSB_FIRST`, default 1: 1 sends `in_data[DATA_W-1]` first; 0 sends `in_data[0]` first.
- `clk` input, 1: single clock; all logic is rising-edge.
- `rst` input, 1: synchronous, active-low reset.
- `in_valid` input, 1: upstream word available.
- `in_ready` output, 1: framer can accept a word this cycle.
- `in_data` input, `DATA_W`: payload; sampled only on handshake.
- `serial_out` output, 1: framed bitstream, registered.
- `busy` output, 1: high while a frame is in START, DATA or PARITY.
- `frame_done` output, 1: one-cycle pulse coincident with the stop bit.

## Operation
- A handshake occurs when `in_valid && in_ready` at a rising edge. `in_data` is copied into an internal shift register; parity is computed at the same time.
- FSM states are IDLE, START, DATA, PARITY and STOP. PARITY exists only when the parity macro is defined.
- IDLE: `serial_out`=0 and `in_ready`=1. A handshake moves the FSM to START.
- START: `serial_out`=1 for exactly one cycle, then the FSM moves to DATA.
- DATA: `DATA_W` consecutive cycles, one payload bit per cycle, in `MSB_FIRST` order.
  - A bit counter of width `$clog2(DATA_W)` counts 0..`DATA_W`-1.
  - When the counter reaches `DATA_W`-1, the FSM moves to PARITY, or to STOP if parity is compiled out.
- PARITY: `serial_out` = XOR of the captured payload (even parity) for one cycle, then the FSM moves to STOP.
- STOP: `serial_out`=0 for one cycle, `frame_done`=1 and `in_ready`=1.
  - A handshake in STOP goes directly to START (back-to-back frames).
  - Without a handshake, the FSM goes to IDLE.
- `in_ready` is decoded from the state register: high in IDLE and STOP, low otherwise.
- `in_valid` and `in_data` are ignored when `in_ready`=0. No word is dropped or corrupted by upstream activity mid-frame.
- Reset with `rst`=0 at a rising edge, at any time including mid-frame:
  - The frame is abandoned; the FSM goes to IDLE, the counter to 0 and the shift register to 0.
  - `serial_out`=0, `busy`=0, `frame_done`=0. `in_ready`=1 from the first cycle after reset.
  - Reset has priority over a simultaneous handshake; the offered word is not accepted.

## Timing
- Reset values: `serial_out`=0, `busy`=0, `frame_done`=0, `in_ready`=1 (IDLE).
- With a handshake at edge T:
  - Start bit is on `serial_out` during cycle T..T+1.
  - Data bit k (0-based in send order) appears in cycle T+1+k.
  - Parity, if enabled, appears in cycle T+1+`DATA_W`.
  - The stop bit follows.
- Frame length is `DATA_W`+2 cycles without parity and `DATA_W`+3 with parity. This is also the maximum sustained rate: one word per frame length.
- A handshake in STOP produces the next start bit in the very next cycle. No idle gap beyond the stop bit is inserted.
- `busy` and `frame_done` are registered and aligned with `serial_out`.

## Configuration
- `PISO_FRAMER_PARITY_EN` defined: the PARITY state is present and an even-parity bit follows the data; the frame is `DATA_W`+3 bits.
- `PISO_FRAMER_PARITY_EN` undefined: there is no PARITY state and no parity logic; DATA goes directly to STOP and the frame is `DATA_W`+2 bits.

## Structure
- The shared package `piso_framer_pkg` holds:
  - the state typedef `piso_state_t` (IDLE, START, DATA, PARITY, STOP);
  - the constants `START_BIT`=1'b1, `STOP_BIT`=1'b0 and `IDLE_LEVEL`=1'b0.
- Single module with no sub-module. The FSM, counter, shift register and parity XOR are all local.

## Test plan
- Reset then IDLE: hold `rst`=0 for 2 cycles, then release. Expect `serial_out`=0, `busy`=0, `frame_done`=0 and `in_ready`=1, stable for 5 idle cycles.
- Single frame, `DATA_W`=8, `MSB_FIRST`=1, no parity: send 0xA5.
  - Expect `serial_out` = 1,1,0,1,0,0,1,0,1,0.
  - Expect `frame_done` high only on the last bit and `busy` high for 9 cycles.
- Parity enabled: send 0xA5 and expect parity bit 0; send 0x07 and expect parity bit 1. Each frame is 11 bits.
- Back-to-back: hold `in_valid`=1 with 0xFF followed by 0x00. The second start bit appears in the cycle immediately after the first stop bit, with no extra idle cycle.
- Ignore while busy: change `in_data` to 0x3C with `in_valid`=1 during DATA of a 0x81 frame. Expect the transmitted payload to remain 0x81.
- Reset mid-frame and LSB-first:
  - Assert `rst`=0 during data bit 3. Expect `serial_out`=0 and `in_ready`=1 the next cycle, with no `frame_done`.
  - Then with `MSB_FIRST`=0, send 0x01. Expect `serial_out` = 1,1,0,0,0,0,0,0,0,0.
